// File: rtl/usb_fs_tx_feeder_if.sv
// Request, packet-buffer and serializer signals of the full-speed USB transmit feeder.
// The slave modport is the feeder; the master modport is its environment.
interface usb_fs_tx_feeder_if #(
    parameter int unsigned AddrW = 9,
    parameter int unsigned SizeW = 7
);
    logic             req_i;
    logic [3:0]       req_pid_i;
    logic [AddrW-1:0] req_addr_i;
    logic [SizeW-1:0] req_size_i;
    logic             busy_o;
    logic             done_o;
    logic             mem_req_o;
    logic [AddrW-1:0] mem_addr_o;
    logic [31:0]      mem_rdata_i;
    logic             pkt_start_o;
    logic [3:0]       pid_o;
    logic             tx_data_avail_o;
    logic [7:0]       tx_data_o;
    logic             tx_data_get_i;
    logic             pkt_end_i;

    modport slave (
        input  req_i, req_pid_i, req_addr_i, req_size_i, mem_rdata_i, tx_data_get_i, pkt_end_i,
        output busy_o, done_o, mem_req_o, mem_addr_o, pkt_start_o, pid_o, tx_data_avail_o,
               tx_data_o
    );

    modport master (
        output req_i, req_pid_i, req_addr_i, req_size_i, mem_rdata_i, tx_data_get_i, pkt_end_i,
        input  busy_o, done_o, mem_req_o, mem_addr_o, pkt_start_o, pid_o, tx_data_avail_o,
               tx_data_o
    );
endinterface

// File: rtl/usb_fs_tx_feeder.sv
// Packet-level front end for the FS USB serializer: fetches the payload from the 32-bit
// packet buffer, starts the packet, streams bytes over avail/get and reports completion.
module usb_fs_tx_feeder #(
    parameter int unsigned AddrW = 9,
    parameter int unsigned SizeW = 7
) (
    input logic               clk_i,
    input logic               rst_ni,
    input logic               link_reset_i,
    usb_fs_tx_feeder_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StFetch, StStart, StStream, StWaitEnd} state_e;

    state_e           state_q;
    logic [3:0]       pid_q;
    logic [AddrW-1:0] addr_q;
    logic [SizeW-1:0] size_q;
    logic [SizeW-1:0] sent_q;
    logic [31:0]      word_q;
    logic             word_valid_q;
    logic             refill_q;
    logic             is_data_q;
    logic             busy_q;
    logic             done_q;

    logic             req_is_data;
    logic             start_fetch;
    logic             avail;
    logic             take;
    logic             refill_now;
    logic [1:0]       byte_idx;
    logic [SizeW-1:0] sent_inc;
    logic [AddrW-1:0] next_addr;

    always_comb begin
        req_is_data = (bus.req_pid_i[1:0] == 2'b11);
        start_fetch = (state_q == StIdle) && bus.req_i && req_is_data &&
                      (bus.req_size_i != '0) && !link_reset_i;
        byte_idx    = sent_q[1:0];
        sent_inc    = sent_q + SizeW'(1);
        next_addr   = addr_q + AddrW'(1);
        avail       = (state_q == StStream) && word_valid_q && (sent_q != size_q) && !link_reset_i;
        take        = avail && bus.tx_data_get_i;
        // Last byte of a word consumed with more to come: fetch the next word right away.
        refill_now  = take && (byte_idx == 2'd3) && (sent_inc != size_q);
    end

    assign bus.mem_req_o       = start_fetch || refill_now;
    assign bus.mem_addr_o      = start_fetch ? bus.req_addr_i : (refill_now ? next_addr : '0);
    assign bus.pkt_start_o     = (state_q == StStart) && !link_reset_i;
    assign bus.busy_o          = busy_q;
    assign bus.done_o          = done_q;
    assign bus.pid_o           = pid_q;
    assign bus.tx_data_avail_o = avail;
    assign bus.tx_data_o       = word_q[{byte_idx, 3'b000} +: 8];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            pid_q        <= '0;
            addr_q       <= '0;
            size_q       <= '0;
            sent_q       <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            refill_q     <= 1'b0;
            is_data_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else if (link_reset_i) begin
            // Bus reset aborts silently: no completion is reported.
            state_q      <= StIdle;
            pid_q        <= '0;
            addr_q       <= '0;
            size_q       <= '0;
            sent_q       <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            refill_q     <= 1'b0;
            is_data_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.req_i) begin
                        pid_q        <= bus.req_pid_i;
                        addr_q       <= bus.req_addr_i;
                        size_q       <= req_is_data ? bus.req_size_i : '0;
                        is_data_q    <= req_is_data;
                        sent_q       <= '0;
                        word_valid_q <= 1'b0;
                        refill_q     <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= start_fetch ? StFetch : StStart;
                    end
                end
                StFetch: begin
                    word_q       <= bus.mem_rdata_i;
                    word_valid_q <= 1'b1;
                    state_q      <= StStart;
                end
                StStart: begin
                    state_q <= is_data_q ? StStream : StWaitEnd;
                end
                StStream: begin
                    if (refill_q) begin
                        word_q       <= bus.mem_rdata_i;
                        word_valid_q <= 1'b1;
                        refill_q     <= 1'b0;
                    end
                    if (take) begin
                        sent_q <= sent_inc;
                        if (refill_now) begin
                            word_valid_q <= 1'b0;
                            addr_q       <= next_addr;
                            refill_q     <= 1'b1;
                        end
                    end
                    // Payload exhausted; the serializer appends CRC and EOP on its own.
                    if (sent_q == size_q) begin
                        state_q <= StWaitEnd;
                    end
                end
                StWaitEnd: begin
                    if (bus.pkt_end_i) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_fs_tx_feeder.sv
// Scoreboard bench for usb_fs_tx_feeder: stimulus pushes expected reads, bytes and starts;
// a negedge monitor pops and compares them as the DUT presents them.
module tb_usb_fs_tx_feeder;
    localparam int unsigned AddrW = 9;
    localparam int unsigned SizeW = 7;
    localparam int unsigned Words = 1 << AddrW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic link_reset = 1'b0;
    int   cyc = 0;
    int   errs = 0;
    int   chks = 0;

    logic [31:0]      sram [Words];
    logic [7:0]       exp_bytes [$];
    logic [AddrW-1:0] exp_addr [$];
    int               exp_start_cyc [$];
    logic [3:0]       exp_start_pid [$];
    int               exp_done = 0;
    int               budget = 0;
    int               taken = 0;
    int               pkt_size = 0;
    int               gap_state = 0;
    bit               spur_en = 1'b0;
    bit               prev_done = 1'b0;

    usb_fs_tx_feeder_if #(.AddrW(AddrW), .SizeW(SizeW)) bus ();

    usb_fs_tx_feeder #(.AddrW(AddrW), .SizeW(SizeW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .link_reset_i (link_reset),
        .bus          (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM: data valid exactly one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        if (bus.mem_req_o) bus.mem_rdata_i <= sram[bus.mem_addr_o];
        else               bus.mem_rdata_i <= 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        logic get_next;
        forever begin
            @(negedge clk);
            get_next = 1'b0;
            if (rst_n) begin
                if (bus.pkt_start_o) begin
                    if (exp_start_cyc.size() == 0) begin
                        check("pkt_start_unexpected", 32'(bus.pkt_start_o), 32'd0);
                    end else begin
                        check("pkt_start_cycle", 32'(cyc), 32'(exp_start_cyc.pop_front()));
                        check("pkt_start_pid", 32'(bus.pid_o), 32'(exp_start_pid.pop_front()));
                    end
                end
                if (bus.done_o) begin
                    check("done_busy_low", 32'(bus.busy_o), 32'd0);
                    check("done_pulse_width", 32'(prev_done), 32'd0);
                    if (exp_done == 0) check("done_unexpected", 32'(bus.done_o), 32'd0);
                    else exp_done--;
                end
                prev_done = bus.done_o;
                if (gap_state == 2) begin
                    check("gap_high", 32'(bus.tx_data_avail_o), 32'd1);
                    gap_state = 0;
                end else if (gap_state == 1) begin
                    check("gap_low", 32'(bus.tx_data_avail_o), 32'd0);
                    gap_state = 2;
                    get_next  = spur_en;
                end
                if (bus.tx_data_avail_o && taken >= pkt_size) begin
                    check("avail_unexpected", 32'(bus.tx_data_avail_o), 32'd0);
                end else if (bus.tx_data_avail_o && budget > 0) begin
                    if (exp_bytes.size() == 0)
                        check("byte_unexpected", 32'(bus.tx_data_avail_o), 32'd0);
                    else
                        check("byte", 32'(bus.tx_data_o), 32'(exp_bytes.pop_front()));
                    if (taken % 4 == 3 && taken + 1 != pkt_size) gap_state = 1;
                    taken++;
                    budget--;
                    get_next = 1'b1;
                end
            end
            bus.tx_data_get_i = get_next;
            #1;
            if (rst_n && bus.mem_req_o) begin
                if (exp_addr.size() == 0)
                    check("mem_req_unexpected", 32'(bus.mem_req_o), 32'd0);
                else
                    check("mem_addr", 32'(bus.mem_addr_o), 32'(exp_addr.pop_front()));
            end
        end
    endtask

    task automatic push_payload(input logic [AddrW-1:0] addr, input int nbytes);
        logic [AddrW-1:0] wa;
        logic [31:0]      w;
        for (int k = 0; k < (nbytes + 3) / 4; k++) exp_addr.push_back(addr + AddrW'(k));
        for (int k = 0; k < nbytes; k++) begin
            wa = addr + AddrW'(k / 4);
            w  = sram[wa];
            exp_bytes.push_back(w[8 * (k % 4) +: 8]);
        end
    endtask

    task automatic issue(input logic [3:0] pid, input logic [AddrW-1:0] addr,
                         input logic [SizeW-1:0] size, input int lat, input int eff_size,
                         input int n_take, input bit spur);
        pkt_size  = eff_size;
        taken     = 0;
        budget    = n_take;
        gap_state = 0;
        spur_en   = spur;
        @(posedge clk); #1;
        exp_start_cyc.push_back(cyc + lat);
        exp_start_pid.push_back(pid);
        bus.req_i      = 1'b1;
        bus.req_pid_i  = pid;
        bus.req_addr_i = addr;
        bus.req_size_i = size;
        @(posedge clk); #1;
        bus.req_i      = 1'b0;
        bus.req_pid_i  = 4'hF;
        bus.req_addr_i = '1;
        bus.req_size_i = '1;
        @(negedge clk);
        check("busy_set", 32'(bus.busy_o), 32'd1);
        check("pid_latched", 32'(bus.pid_o), 32'(pid));
    endtask

    task automatic wait_taken();
        int n = 0;
        while (budget > 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("stream_budget_left", 32'(budget), 32'd0);
    endtask

    task automatic finish_pkt(input logic [3:0] pid, input bit req_mid);
        int n = 0;
        bit mid = 1'b0;
        while (budget > 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
            bus.req_i = 1'b0;
            if (req_mid && !mid && taken == 2) begin
                bus.req_i      = 1'b1;
                bus.req_pid_i  = 4'b0010;
                bus.req_size_i = '0;
                mid = 1'b1;
            end
        end
        bus.req_i = 1'b0;
        check("stream_budget_left", 32'(budget), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pid_hold", 32'(bus.pid_o), 32'(pid));
        check("busy_hold", 32'(bus.busy_o), 32'd1);
        @(posedge clk); #1;
        bus.pkt_end_i = 1'b1;
        exp_done++;
        @(posedge clk); #1;
        bus.pkt_end_i = 1'b0;
        repeat (2) @(negedge clk);
        check("done_seen", 32'(exp_done), 32'd0);
        check("busy_clear", 32'(bus.busy_o), 32'd0);
        check("bytes_left", 32'(exp_bytes.size()), 32'd0);
        check("reads_left", 32'(exp_addr.size()), 32'd0);
        check("starts_left", 32'(exp_start_cyc.size()), 32'd0);
    endtask

    initial begin
        bus.req_i         = 1'b0;
        bus.req_pid_i     = '0;
        bus.req_addr_i    = '0;
        bus.req_size_i    = '0;
        bus.tx_data_get_i = 1'b0;
        bus.pkt_end_i     = 1'b0;
        for (int i = 0; i < Words; i++) sram[i] = 32'h9E37_79B9 * 32'(i + 1);
        sram[9'h010] = 32'h4433_2211;
        sram[9'h011] = 32'h0000_00AA;

        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
        check("rst_pkt_start", 32'(bus.pkt_start_o), 32'd0);
        check("rst_avail", 32'(bus.tx_data_avail_o), 32'd0);
        check("rst_pid", 32'(bus.pid_o), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // pkt_end while idle must not produce done
        bus.pkt_end_i = 1'b1;
        @(posedge clk); #1;
        bus.pkt_end_i = 1'b0;

        // ACK: size ignored, no reads, start after 1 cycle
        issue(4'b0010, 9'h033, 7'd5, 1, 0, 0, 1'b0);
        finish_pkt(4'b0010, 1'b0);

        // DATA0, 5 bytes spanning two words
        exp_addr.push_back(9'h010);
        exp_addr.push_back(9'h011);
        exp_bytes.push_back(8'h11);
        exp_bytes.push_back(8'h22);
        exp_bytes.push_back(8'h33);
        exp_bytes.push_back(8'h44);
        exp_bytes.push_back(8'hAA);
        issue(4'b0011, 9'h010, 7'd5, 2, 5, 5, 1'b0);
        finish_pkt(4'b0011, 1'b0);

        // DATA1 with empty payload
        issue(4'b1011, 9'h0A0, 7'd0, 1, 0, 0, 1'b0);
        finish_pkt(4'b1011, 1'b0);

        // DATA0, max size, buffer address wraps
        push_payload(9'h1FE, 64);
        issue(4'b0011, 9'h1FE, 7'd64, 2, 64, 64, 1'b0);
        finish_pkt(4'b0011, 1'b0);

        // Bus reset after the third byte of an 8-byte packet
        push_payload(9'h020, 3);
        issue(4'b0011, 9'h020, 7'd8, 2, 8, 3, 1'b0);
        wait_taken();
        repeat (2) @(posedge clk);
        #1 link_reset = 1'b1;
        @(posedge clk); #1;
        link_reset = 1'b0;
        @(negedge clk);
        check("lrst_busy", 32'(bus.busy_o), 32'd0);
        check("lrst_avail", 32'(bus.tx_data_avail_o), 32'd0);
        check("lrst_done", 32'(bus.done_o), 32'd0);
        check("lrst_pid", 32'(bus.pid_o), 32'd0);
        check("lrst_reads_left", 32'(exp_addr.size()), 32'd0);
        pkt_size = 0;
        repeat (3) @(posedge clk);

        // Request during Stream and a get during the refill gap are both ignored
        push_payload(9'h040, 8);
        issue(4'b1011, 9'h040, 7'd8, 2, 8, 8, 1'b1);
        finish_pkt(4'b1011, 1'b1);

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end
endmodule

// File: doc/usb_fs_tx_feeder.md
Name: usb_fs_tx_feeder

Overview:
Packet-level front end for the full-speed USB serializer. It takes a transmit request (PID, buffer word address, byte count) and reads the payload from the 32-bit packet buffer SRAM. It issues the one-cycle packet start to the serializer and presents payload bytes over the avail/get handshake. It holds until the serializer reports end of packet, then signals completion to the endpoint logic.

Parameters:
AddrW, 9, packet buffer word address width (32-bit words)
SizeW, 7, byte count width (0..64 bytes, max FS packet)

Ports:
clk_i  in  1  48 MHz clock
rst_ni  in  1  asynchronous reset, active low
link_reset_i  in  1  USB bus reset, synchronous to clk_i, active high
req_i  in  1  start request pulse; sampled only in Idle
req_pid_i  in  4  PID to send
req_addr_i  in  AddrW  word address of first payload byte
req_size_i  in  SizeW  payload byte count
busy_o  out  1  high from accepted request until done
done_o  out  1  one-cycle pulse on packet completion
mem_req_o  out  1  SRAM read strobe
mem_addr_o  out  AddrW  SRAM word address
mem_rdata_i  in  32  SRAM read data, valid exactly 1 cycle after mem_req_o
pkt_start_o  out  1  one-cycle packet start to serializer
pid_o  out  4  PID, held stable while busy_o
tx_data_avail_o  out  1  payload byte available
tx_data_o  out  8  payload byte
tx_data_get_i  in  1  serializer consumed current byte (pulse)
pkt_end_i  in  1  serializer finished EOP (pulse)

Behaviour:
- Async reset and link_reset_i: FSM to Idle. Clear all regs. All outputs 0. No done_o is produced by link_reset_i, including mid-packet.
- Data packet: req_pid_i[1:0]==2'b11. Otherwise the request is a token/handshake: size is ignored and no SRAM reads occur.
- FSM states: Idle, Fetch, Start, Stream, WaitEnd.
- Idle, req_i=1:
  - Latch pid, addr, size. Set busy_o next cycle.
  - Data packet with size>0: assert mem_req_o with mem_addr_o=req_addr_i in the same cycle, then go to Fetch.
  - Otherwise go to Start.
- Fetch (1 cycle): capture mem_rdata_i into word register, set word_valid, go to Start.
- Start (1 cycle): pkt_start_o=1. Go to Stream if data packet, else WaitEnd.
- Stream:
  - tx_data_avail_o = word_valid && (sent_cnt != size).
  - tx_data_o = word[8*byte_idx +: 8], little-endian, byte_idx = sent_cnt[1:0].
  - tx_data_avail_o and tx_data_o are stable until tx_data_get_i.
  - tx_data_get_i with avail: sent_cnt++.
  - If byte_idx was 3 and sent_cnt+1 != size: clear word_valid, assert mem_req_o at word address+1 the same cycle, and reload word_valid the next cycle. Avail drops for exactly 1 cycle.
  - tx_data_get_i while avail=0: ignored, no count change.
  - sent_cnt==size: avail=0 (serializer then emits CRC). Go to WaitEnd.
  - size==0 data packet: avail never asserts.
- WaitEnd: on pkt_end_i, pulse done_o for one cycle, deassert busy_o the same cycle, go to Idle.
- pkt_end_i in any other state is ignored.
- req_i while busy_o: ignored, no queuing.
- Address arithmetic wraps modulo 2^AddrW.
- Latency: for size>0, req_i to pkt_start_o is 2 cycles; for size==0 or non-data PID, 1 cycle.
- At most one mem_req_o outstanding. Total reads per packet = ceil(size/4).

Test Plan:
- ACK (pid 4'b0010, size 5) -> no mem_req_o; pkt_start_o 1 cycle after req_i; avail never high; pkt_end_i -> done_o pulse, busy_o low.
- DATA0 (4'b0011), addr 0x10, size 5, SRAM[0x10]=0x44332211, SRAM[0x11]=0x000000AA -> reads at 0x10, 0x11 only; bytes 11,22,33,44,AA in order; avail low after 5th get.
- DATA1 (4'b1011), size 0 -> no reads; pkt_start_o after 1 cycle; avail stays 0; done_o on pkt_end_i.
- DATA0, size 64, addr 2^AddrW-2 -> 16 reads, addresses wrap to 0; 64 bytes delivered; avail gap exactly 1 cycle at each word boundary.
- link_reset_i asserted after 3rd get of an 8-byte packet -> next cycle busy_o=0, avail=0, no done_o; subsequent request works normally.
- req_i pulsed during Stream, plus a spurious tx_data_get_i during the refill gap -> both ignored; byte sequence unchanged.
